// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the 8-bit stack CPU (controller and datapath).
// Holds the opcode map, the ALU operation codes, the ALU A-input select codes
// and the controller state encoding.
package stack_cpu_pkg;

  // Opcodes, taken from inst[7:5]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  // ALU operation codes (NOT computes ~A)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_NOT = 3'b011;

  // ALU A-input select (s3)
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_PC   = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;

  typedef enum logic [3:0] {
    ST_IF      = 4'd0,
    ST_ID      = 4'd1,
    ST_POP_A   = 4'd2,
    ST_POP_B   = 4'd3,
    ST_EXEC    = 4'd4,
    ST_WB      = 4'd5,
    ST_MEM_RD  = 4'd6,
    ST_PUSH_WB = 4'd7,
    ST_MEM_WR  = 4'd8,
    ST_TOP_A   = 4'd9,
    ST_JZ_TEST = 4'd10
  } state_t;

  // ALU operation for the arithmetic/logic opcodes (0xx)
  function automatic logic [2:0] alu_for_op(input logic [2:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_NOT:  return ALU_NOT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/stack_controller_if.sv
// Control bus between the stack controller and the stack-machine datapath.
//   inst, Zero        : datapath -> controller (IR byte, ALU result == 0)
//   ld_PC/ld_IR/ld_A  : register loads
//   MemRead/MemWrite  : memory strobes
//   push/pop/top      : stack operations
//   PCsrc, s1..s4     : datapath mux selects
//   ALU_operation     : ALU function
//   instr_done        : pulse in the last state of each instruction
// master = controller side, slave = datapath side.
interface stack_controller_if #(
  parameter int ALUW = 3
);
  logic [7:0]      inst;
  logic            Zero;
  logic            ld_PC;
  logic            ld_IR;
  logic            ld_A;
  logic            MemRead;
  logic            MemWrite;
  logic            push;
  logic            pop;
  logic            top;
  logic            PCsrc;
  logic            s1;
  logic            s2;
  logic [1:0]      s3;
  logic            s4;
  logic [ALUW-1:0] ALU_operation;
  logic            instr_done;

  modport master (
    input  inst, Zero,
    output ld_PC, ld_IR, ld_A, MemRead, MemWrite, push, pop, top,
           PCsrc, s1, s2, s3, s4, ALU_operation, instr_done
  );

  modport slave (
    output inst, Zero,
    input  ld_PC, ld_IR, ld_A, MemRead, MemWrite, push, pop, top,
           PCsrc, s1, s2, s3, s4, ALU_operation, instr_done
  );
endinterface

// File: rtl/stack_controller.sv
// Multicycle control FSM for the 8-bit stack-machine datapath.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset; outputs are held at 0 while low
//   bus : control bus (master side); decodes bus.inst[7:5], uses bus.Zero
//         only in JZ_TEST, drives every datapath control.
module stack_controller
  import stack_cpu_pkg::*;
#(
  parameter int OPW  = 3,
  parameter int ALUW = 3
) (
  input  logic               clk,
  input  logic               rst,
  stack_controller_if.master bus
);

  state_t           state;
  state_t           state_nxt;
  logic [OPW-1:0]   opcode;
  logic [2:0]       alu_op;
  logic             unused_addr;

  assign opcode      = bus.inst[7 -: OPW];
  // The address field is consumed by the datapath, not here.
  assign unused_addr = ^bus.inst[4:0];

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IF;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = ST_IF;
    alu_op         = ALU_ADD;
    bus.ld_PC      = 1'b0;
    bus.ld_IR      = 1'b0;
    bus.ld_A       = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.top        = 1'b0;
    bus.PCsrc      = 1'b0;
    bus.s1         = 1'b0;
    bus.s2         = 1'b0;
    bus.s3         = SEL_A;
    bus.s4         = 1'b0;
    bus.instr_done = 1'b0;

    // Outputs stay at zero during the reset cycle so an aborted
    // instruction leaves no stack or memory side effect.
    if (rst) begin
      case (state)
        ST_IF: begin
          // Fetch and PC <- PC + 1 in the same cycle
          bus.MemRead = 1'b1;
          bus.ld_IR   = 1'b1;
          bus.s3      = SEL_PC;
          bus.s2      = 1'b1;
          bus.ld_PC   = 1'b1;
          state_nxt   = ST_ID;
        end
        ST_ID: begin
          if (opcode == OPW'(OP_PUSH)) begin
            state_nxt = ST_MEM_RD;
          end else if (opcode == OPW'(OP_JMP)) begin
            bus.PCsrc      = 1'b1;
            bus.ld_PC      = 1'b1;
            bus.instr_done = 1'b1;
            state_nxt      = ST_IF;
          end else if (opcode == OPW'(OP_JZ)) begin
            state_nxt = ST_TOP_A;
          end else begin
            state_nxt = ST_POP_A;   // ALU ops and POP
          end
        end
        ST_POP_A: begin
          bus.pop  = 1'b1;
          bus.ld_A = 1'b1;
          if (opcode == OPW'(OP_NOT))      state_nxt = ST_EXEC;
          else if (opcode == OPW'(OP_POP)) state_nxt = ST_MEM_WR;
          else                             state_nxt = ST_POP_B;
        end
        ST_POP_B: begin
          bus.pop   = 1'b1;
          state_nxt = ST_EXEC;
        end
        ST_EXEC: begin
          alu_op    = alu_for_op(3'(opcode));
          state_nxt = ST_WB;
        end
        ST_WB: begin
          bus.push       = 1'b1;
          bus.s4         = 1'b1;
          bus.instr_done = 1'b1;
        end
        ST_MEM_RD: begin
          bus.MemRead = 1'b1;
          bus.s1      = 1'b1;
          state_nxt   = ST_PUSH_WB;
        end
        ST_PUSH_WB: begin
          bus.push       = 1'b1;
          bus.instr_done = 1'b1;
        end
        ST_MEM_WR: begin
          bus.MemWrite   = 1'b1;
          bus.s1         = 1'b1;
          bus.instr_done = 1'b1;
        end
        ST_TOP_A: begin
          bus.top   = 1'b1;
          bus.ld_A  = 1'b1;
          state_nxt = ST_JZ_TEST;
        end
        ST_JZ_TEST: begin
          // A AND B with A == B == top: Zero means top of stack is 0
          alu_op         = ALU_AND;
          bus.instr_done = 1'b1;
          if (bus.Zero) begin
            bus.PCsrc = 1'b1;
            bus.ld_PC = 1'b1;
          end
        end
        default: state_nxt = ST_IF;   // illegal encodings recover to fetch
      endcase
    end
  end

  assign bus.ALU_operation = ALUW'(alu_op);

endmodule
